// File: rtl/aplic_src_gateway.sv
// APLIC per-source gateway: polarity rectification, edge capture and round-robin
// serialisation of set-pending requests. Define APLIC_GW_SYNC_EN to add 2-flop input synchronisers.
module aplic_src_gateway #(
  parameter  int unsigned NR_SRC = 32,
  localparam int unsigned SRCW   = $clog2(NR_SRC)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NR_SRC-1:0]     irq_src_i,
  input  logic [3*NR_SRC-1:0]   sm_i,
  input  logic [NR_SRC-1:0]     ip_i,
  output logic [NR_SRC-1:0]     rectified_o,
  output logic                  req_valid_o,
  output logic [SRCW-1:0]       req_id_o,
  input  logic                  req_ready_i
);

  localparam logic [2:0] SM_EDGE1  = 3'd4;
  localparam logic [2:0] SM_EDGE0  = 3'd5;
  localparam logic [2:0] SM_LEVEL1 = 3'd6;
  localparam logic [2:0] SM_LEVEL0 = 3'd7;

  typedef enum logic {S_IDLE, S_OFFER} state_e;

  state_e            r_state;
  logic [NR_SRC-1:0] r_prev;
  logic [NR_SRC-1:0] r_evt;
  logic [SRCW-1:0]   r_ptr;

  logic [NR_SRC-1:0] w_s;
  logic [NR_SRC-1:0] w_rect;
  logic [NR_SRC-1:0] w_evt_nxt;
  logic [NR_SRC-1:0] w_cand;
  logic              w_hs;
  logic              w_found;
  logic [SRCW-1:0]   w_win;
  logic [SRCW-1:0]   w_ptr_nxt;
  int unsigned       w_idx;

`ifdef APLIC_GW_SYNC_EN
  logic [NR_SRC-1:0] r_sync1;
  logic [NR_SRC-1:0] r_sync2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_src_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = irq_src_i;
`endif

  assign w_hs = req_valid_o & req_ready_i;

  // Per-source mode decode; bit 0 of the mode selects inverted polarity.
  for (genvar i = 0; i < NR_SRC; i++) begin : g_src
    logic [2:0] w_m;
    logic       w_is_edge;
    logic       w_is_lvl;
    logic       w_edge_evt;
    logic       w_clr;

    assign w_m        = sm_i[3*i +: 3];
    assign w_is_edge  = (w_m == SM_EDGE1) || (w_m == SM_EDGE0);
    assign w_is_lvl   = (w_m == SM_LEVEL1) || (w_m == SM_LEVEL0);
    assign w_edge_evt = w_is_edge && (w_s[i] ^ w_m[0]) && !(r_prev[i] ^ w_m[0]);
    assign w_clr      = w_hs && (req_id_o == SRCW'(i));

    assign w_rect[i]    = (i != 0) && (w_is_edge || w_is_lvl) && (w_s[i] ^ w_m[0]);
    assign w_evt_nxt[i] = (i != 0) && w_is_edge && (w_edge_evt || (r_evt[i] && !w_clr));
    assign w_cand[i]    = (i != 0) && (r_evt[i] || (w_is_lvl && w_rect[i] && !ip_i[i]));
  end

  assign rectified_o = w_rect;

  // Round-robin search from r_ptr over IDs 1..NR_SRC-1.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NR_SRC - 1; k++) begin
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= NR_SRC) w_idx = w_idx - (NR_SRC - 1);
      if (!w_found && w_cand[SRCW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = SRCW'(w_idx);
      end
    end
  end

  assign w_ptr_nxt = (req_id_o == SRCW'(NR_SRC - 1)) ? SRCW'(1) : req_id_o + SRCW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_prev      <= '0;
      r_evt       <= '0;
      r_ptr       <= SRCW'(1);
      req_valid_o <= 1'b0;
      req_id_o    <= '0;
    end else begin
      r_prev <= w_s;
      r_evt  <= w_evt_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            req_id_o    <= w_win;
            req_valid_o <= 1'b1;
            r_state     <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (req_ready_i) begin
            req_valid_o <= 1'b0;
            r_ptr       <= w_ptr_nxt;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aplic_src_gateway.md
Name: aplic_src_gateway

Overview:
- Per-source front end for the APLIC interrupt-pending logic.
- Applies each source's configured source mode to its wire:
  - rectifies polarity;
  - detects edges;
  - holds edge events until they are delivered.
- Serialises set-pending requests to the IP register bank, one per handshake, with round-robin arbitration among sources.
- Sits between the raw interrupt wires and the IP/IE register bank of the APLIC domain.

Parameters:
- NR_SRC, 32, number of source slots incl. reserved source 0 (legal 2..1024).
- SRCW, $clog2(NR_SRC), width of source ID (derived; not overridable).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- irq_src_i  in  NR_SRC  raw interrupt wires; bit 0 ignored.
- sm_i  in  3*NR_SRC  source mode per source, bits [3i+2:3i]:
  - 0 inactive, 1 detached, 4 edge1, 5 edge0, 6 level1, 7 level0;
  - 2/3 reserved, treated as inactive.
- ip_i  in  NR_SRC  current pending bits from the IP bank.
- rectified_o  out  NR_SRC  rectified input value per source (readable via in_clrip).
- req_valid_o  out  1  set-pending request valid.
- req_id_o  out  SRCW  source ID of the request.
- req_ready_i  in  1  IP bank accepts the request this cycle.

Behaviour:
- Sampled input s[i]:
  - irq_src_i[i] directly, or the synchronised copy (see Optional Feature).
- prev[i] register:
  - tracks s[i] every cycle, regardless of mode;
  - reset value 0.
- rectified_o[i] (combinational from s[i], sm_i):
  - s[i] for edge1/level1;
  - ~s[i] for edge0/level0;
  - 0 for inactive/detached/reserved;
  - bit 0 always 0.
- Edge event:
  - edge1: s=1 and prev=0; edge0: s=0 and prev=1.
  - On an edge event, evt[i] is set the next cycle.
  - evt[i] is cleared the cycle after source i's request handshakes (req_valid_o & req_ready_i with req_id_o=i).
  - Set wins over clear in the same cycle, so a new edge arriving during the accepted handshake is not lost.
  - Repeated edges while evt[i] is already set merge into a single request.
- Mode change to a non-edge mode clears evt[i] next cycle.
- Level request (combinational, no flag):
  - lvl[i] = rectified_o[i] & ~ip_i[i], for level modes only.
- Candidate set: cand[i] = evt[i] | lvl[i], for i >= 1. Detached and inactive sources never request.
- Arbiter:
  - Round-robin pointer ptr, reset value 1.
  - Search starts at ptr and wraps from NR_SRC-1 back to 1, skipping 0.
  - On handshake: ptr <= granted ID + 1, wrapping NR_SRC-1 -> 1.
- Output register (two states):
  - IDLE: req_valid_o=0. If any candidate exists, load req_id_o with the winner, set req_valid_o=1, go to OFFER.
  - OFFER: hold req_valid_o and req_id_o stable until req_ready_i.
    - On handshake: req_valid_o=0, go to IDLE.
    - There is a one-cycle bubble, so at most one request per 2 cycles, and a source whose pending bit just set is not re-requested.
  - An offer is never retracted, even if the source's mode or input changes during OFFER. The IP bank qualifies the request.
- Latency (no sync):
  - edge at sample cycle N -> evt set N+1 -> req_valid_o high N+2.
  - Level asserted at N -> req_valid_o high N+1.
- Reset values: req_valid_o=0, req_id_o=0, evt=0, prev=0, ptr=1, sync flops=0. Reset mid-offer drops the request.
- Corner cases:
  - A source configured edge1 while its wire is already high produces no event, because prev already tracks the wire.
  - Source 0 and IDs >= NR_SRC are never issued.

Optional Feature:
- Macro: APLIC_GW_SYNC_EN.
- Defined:
  - each irq_src_i bit passes through a 2-flop synchroniser (reset 0) before s[i];
  - adds 2 cycles to all latencies.
- Undefined:
  - s[i] = irq_src_i[i];
  - inputs must be synchronous to clk_i.

Test Plan:
- Edge1 pulse: sm[3]=4, irq_src_i[3] rises at cycle 10, ready tied 1 -> req_valid_o=1, req_id_o=3 at cycle 12, exactly one request.
- Merge: src 5 edge0, three falling edges while ready=0 -> a single req_id_o=5 is held stable; after ready, no further request.
- Edge during accept: src 2 edge1, second rising edge in the handshake cycle -> a second request for ID 2 follows.
- Level1: src 7 high, ip_i[7]=0 -> request ID 7. Set ip_i[7]=1 after accept -> no further requests. Drop ip_i[7] -> re-request.
- Round-robin: sources 1, 4, 9 all level-active, ip held 0, ready=1 -> grant order 1, 4, 9, 1, 4, … with one-cycle bubbles.
- Reset/mode: reset asserted during OFFER -> req_valid_o=0 immediately. Src 6 set to detached with the wire toggling -> never requested, rectified_o[6]=0. With APLIC_GW_SYNC_EN defined, the test 1 request appears at cycle 14.
